// File: rtl/io_input_conditioner.sv
// Synchronises, debounces and zero-extends board switches/keys for the LSU, and keeps
// sticky write-one-to-clear press flags per key.
module io_input_conditioner #(
  parameter int unsigned NUM_SW          = 18,
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        KEY_IDLE        = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SW-1:0]   sw_raw_i,
  input  logic [NUM_KEYS-1:0] keys_raw_i,
  input  logic [NUM_KEYS-1:0] key_clr_i,
  output logic [31:0]         io_sw_o,
  output logic [31:0]         io_keys_o,
  output logic [NUM_KEYS-1:0] key_evt_o
);

  localparam int unsigned     NB      = NUM_SW + NUM_KEYS;
  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // Switches occupy the low bits, keys the high bits of every per-bit vector.
  localparam logic [NB-1:0]   RST_VAL = {{NUM_KEYS{KEY_IDLE}}, {NUM_SW{1'b0}}};

  logic [NB-1:0]          ff1_q, ff1_d;
  logic [NB-1:0]          s_q, s_d;
  logic [NB-1:0]          deb_q, deb_d;
  logic [NB-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]    evt_q, evt_d;
  logic [NUM_KEYS-1:0]    press;

  // Next-state: sync chain, per-bit debounce counters and sticky press flags.
  always_comb begin
    ff1_d = {keys_raw_i, sw_raw_i};
    s_d   = ff1_q;
    deb_d = deb_q;
    cnt_d = '0;
    press = '0;
    for (int i = 0; i < NB; i++) begin
      if (s_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    for (int k = 0; k < NUM_KEYS; k++) begin
      press[k] = (deb_q[NUM_SW+k] == KEY_IDLE) && (deb_d[NUM_SW+k] != KEY_IDLE);
    end
    // A press on the same edge as a clear keeps the flag set.
    evt_d = (evt_q & ~key_clr_i) | press;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff1_q <= RST_VAL;
      s_q   <= RST_VAL;
      deb_q <= RST_VAL;
      cnt_q <= '0;
      evt_q <= '0;
    end else begin
      ff1_q <= ff1_d;
      s_q   <= s_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
      evt_q <= evt_d;
    end
  end

  assign io_sw_o   = 32'(deb_q[NUM_SW-1:0]);
  assign io_keys_o = 32'(deb_q[NB-1:NUM_SW]);
  assign key_evt_o = evt_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed and randomized bench for io_input_conditioner against a window-based reference model.
module tb_io_input_conditioner;

  localparam int unsigned NS = 18;
  localparam int unsigned NK = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned NB = NS + NK;
  localparam logic [NB-1:0] RSTV = {{NK{1'b1}}, {NS{1'b0}}};

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] sw_raw;
  logic [NK-1:0] keys_raw;
  logic [NK-1:0] key_clr;
  logic [31:0]   io_sw;
  logic [31:0]   io_keys;
  logic [NK-1:0] key_evt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: raw delayed two edges, then a bit flips once the last D delayed
  // samples since reset all disagree with its current debounced value.
  logic [NB-1:0] dl[$];
  logic [NB-1:0] win[$];
  logic [NB-1:0] mq;
  logic [NK-1:0] mevt;

  io_input_conditioner #(
    .NUM_SW(NS), .NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .KEY_IDLE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw_i(sw_raw), .keys_raw_i(keys_raw), .key_clr_i(key_clr),
    .io_sw_o(io_sw), .io_keys_o(io_keys), .key_evt_o(key_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [NB-1:0] s_seen, prev;
    logic [NK-1:0] pr;
    bit all_diff;
    if (rst) begin
      dl.delete(); dl.push_back(RSTV); dl.push_back(RSTV);
      win.delete();
      mq = RSTV;
      mevt = '0;
    end else begin
      s_seen = dl.pop_front();
      dl.push_back({keys_raw, sw_raw});
      win.push_back(s_seen);
      if (win.size() > D) void'(win.pop_front());
      prev = mq;
      if (win.size() == D) begin
        for (int b = 0; b < NB; b++) begin
          all_diff = 1'b1;
          foreach (win[k]) if (win[k][b] == prev[b]) all_diff = 1'b0;
          if (all_diff) mq[b] = ~prev[b];
        end
      end
      for (int k = 0; k < NK; k++) pr[k] = prev[NS+k] & ~mq[NS+k];
      mevt = (mevt & ~key_clr) | pr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_sw", io_sw, 32'(mq[NS-1:0]));
    chk("model_keys", io_keys, 32'(mq[NB-1:NS]));
    chk("model_evt", 32'(key_evt), 32'(mevt));
  endtask

  initial begin
    rst = 1'b1; sw_raw = '0; keys_raw = 4'hF; key_clr = '0;
    mq = RSTV; mevt = '0;

    // Reset held three cycles.
    repeat (3) tick();
    chk("rst_keys", io_keys, 32'h0000_000F);
    chk("rst_sw", io_sw, 32'h0);
    chk("rst_evt", 32'(key_evt), 32'h0);
    rst = 1'b0;
    repeat (3) tick();

    // Clean switch edge: visible exactly at the 2+D'th edge.
    sw_raw[0] = 1'b1;
    repeat (5) tick();
    chk("sw_early", io_sw, 32'h0);
    tick();
    chk("sw_latency", io_sw, 32'h1);

    // Bounce on key 1: three low samples never reach D.
    for (int r = 0; r < 5; r++) begin
      keys_raw[1] = 1'b0; repeat (3) tick();
      keys_raw[1] = 1'b1; repeat (2) tick();
    end
    repeat (3) tick();
    chk("bounce_keys", io_keys, 32'hF);
    chk("bounce_evt", 32'(key_evt), 32'h0);

    // Press and release of key 2.
    keys_raw[2] = 1'b0;
    repeat (5) tick();
    chk("press_early", io_keys, 32'hF);
    tick();
    chk("press_keys", io_keys, 32'hB);
    chk("press_evt", 32'(key_evt), 32'h4);
    repeat (4) tick();
    keys_raw[2] = 1'b1;
    repeat (6) tick();
    chk("release_keys", io_keys, 32'hF);
    chk("release_evt", 32'(key_evt), 32'h4);

    // Clear race: clear coincident with a new press keeps the flag.
    key_clr = 4'b0100; tick(); key_clr = '0;
    chk("clr_evt", 32'(key_evt), 32'h0);
    keys_raw[2] = 1'b0;
    repeat (5) tick();
    key_clr = 4'b0100; tick(); key_clr = '0;
    chk("race_evt", 32'(key_evt), 32'h4);
    key_clr = 4'b0100; tick(); key_clr = '0;
    chk("late_clr_evt", 32'(key_evt), 32'h0);
    keys_raw[2] = 1'b1;
    repeat (8) tick();

    // Reset mid-debounce on key 0 (counter at 2).
    keys_raw[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_sw", io_sw, 32'h0);
    repeat (5) tick();
    chk("mid_rst_hold", io_keys, 32'hF);
    tick();
    chk("mid_rst_fall", io_keys, 32'hE);
    chk("mid_rst_evt", 32'(key_evt), 32'h1);
    keys_raw[0] = 1'b1;
    repeat (8) tick();

    // Randomized phase with bouncy inputs, random clears and rare resets.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NS; b++) if ($urandom_range(0, 7) == 0) sw_raw[b] = ~sw_raw[b];
      for (int b = 0; b < NK; b++) if ($urandom_range(0, 7) == 0) keys_raw[b] = ~keys_raw[b];
      for (int b = 0; b < NK; b++) key_clr[b] = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
